// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared constants for the byte-serial memory arbiter
package mem_ctrl_pkg;

   localparam logic RST_ENABLE = 1'b1;

   // FSM state encodings
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // MEM access size encodings
   localparam logic [1:0] SIZE_BYTE = 2'b01;
   localparam logic [1:0] SIZE_HALF = 2'b10;
   localparam logic [1:0] SIZE_WORD = 2'b11;

   // instruction fetches are always full words
   localparam logic [2:0] IF_BYTES = 3'd4;

   // byte count of a MEM access; the unused 00 code behaves like a byte
   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         SIZE_BYTE: return 3'd1;
         SIZE_HALF: return 3'd2;
         SIZE_WORD: return 3'd4;
         default:   return 3'd1;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - IF/MEM arbiter serialising word/half/byte accesses onto an 8-bit RAM bus
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [31:0]       if_data_o,
   output logic              if_done_o,
   output logic              if_rq_o,
   input  logic              mem_req_i,
   input  logic              mem_we_i,
   input  logic [1:0]        mem_size_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [31:0]       mem_wdata_i,
   output logic [31:0]       mem_rdata_o,
   output logic              mem_done_o,
   output logic              mem_rq_o,
   output logic [ADDR_W-1:0] ram_a_o,
   input  logic [7:0]        ram_dout_i,
   output logic [7:0]        ram_din_o,
   output logic              ram_wr_o
);

   logic [1:0]        state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [2:0]        len_q, len_d;
   logic              own_if_q, own_if_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       buf_q, buf_d;
   logic [31:0]       if_data_q, if_data_d;
   logic [31:0]       mem_rdata_q, mem_rdata_d;
   logic              if_done_q, if_done_d;
   logic              mem_done_q, mem_done_d;

   logic [2:0]        req_len;
   logic [31:0]       rd_shifted;
   logic [31:0]       wr_shifted;
   logic              if_abort;

   // next-state, datapath and RAM bus drive; the accept cycle drives the bus straight from the request
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      own_if_d    = own_if_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      buf_d       = buf_q;
      if_data_d   = if_data_q;
      mem_rdata_d = mem_rdata_q;
      if_done_d   = 1'b0;
      mem_done_d  = 1'b0;
      ram_a_o     = '0;
      ram_din_o   = 8'd0;
      ram_wr_o    = 1'b0;
      req_len     = size_bytes(mem_size_i);
      rd_shifted  = {24'd0, ram_dout_i} << {cnt_q - 3'd1, 3'b000};
      wr_shifted  = wdata_q >> {cnt_q, 3'b000};
      if_abort    = !if_req_i || (if_addr_i != addr_q);

      case (state_q)
         ST_IDLE: begin
            if (rst != RST_ENABLE) begin
               if (mem_req_i) begin
                  own_if_d = 1'b0;
                  addr_d   = mem_addr_i;
                  wdata_d  = mem_wdata_i;
                  len_d    = req_len;
                  buf_d    = 32'd0;
                  cnt_d    = 3'd1;
                  ram_a_o  = mem_addr_i;
                  if (mem_we_i) begin
                     ram_wr_o  = 1'b1;
                     ram_din_o = mem_wdata_i[7:0];
                     if (req_len == 3'd1) begin
                        state_d    = ST_DONE;
                        mem_done_d = 1'b1;
                     end else begin
                        state_d = ST_WRITE;
                     end
                  end else begin
                     state_d = ST_READ;
                  end
               end else if (if_req_i) begin
                  own_if_d = 1'b1;
                  addr_d   = if_addr_i;
                  len_d    = IF_BYTES;
                  buf_d    = 32'd0;
                  cnt_d    = 3'd1;
                  ram_a_o  = if_addr_i;
                  state_d  = ST_READ;
               end
            end
         end
         ST_READ: begin
            // byte cnt-1 arrives now while byte cnt is addressed
            ram_a_o = addr_q + ADDR_W'(cnt_q);
            buf_d   = buf_q | rd_shifted;
            if (own_if_q && if_abort) begin
               state_d = ST_IDLE;
            end else if (cnt_q == len_q) begin
               state_d = ST_DONE;
               if (own_if_q) begin
                  if_done_d = 1'b1;
                  if_data_d = buf_d;
               end else begin
                  mem_done_d  = 1'b1;
                  mem_rdata_d = buf_d;
               end
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         ST_WRITE: begin
            ram_a_o   = addr_q + ADDR_W'(cnt_q);
            ram_din_o = wr_shifted[7:0];
            ram_wr_o  = 1'b1;
            if (cnt_q == len_q - 3'd1) begin
               state_d    = ST_DONE;
               mem_done_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // state and registered outputs, synchronous reset
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 3'd0;
         len_q       <= 3'd0;
         own_if_q    <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= 32'd0;
         buf_q       <= 32'd0;
         if_data_q   <= 32'd0;
         mem_rdata_q <= 32'd0;
         if_done_q   <= 1'b0;
         mem_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         own_if_q    <= own_if_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         buf_q       <= buf_d;
         if_data_q   <= if_data_d;
         mem_rdata_q <= mem_rdata_d;
         if_done_q   <= if_done_d;
         mem_done_q  <= mem_done_d;
      end
   end

   assign if_data_o   = if_data_q;
   assign mem_rdata_o = mem_rdata_q;
   assign if_done_o   = if_done_q;
   assign mem_done_o  = mem_done_q;
   assign if_rq_o     = if_req_i & ~if_done_q;
   assign mem_rq_o    = mem_req_i & ~mem_done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - self-checking bench for mem_ctrl
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic [31:0] if_data_o;
   logic        if_done_o;
   logic        if_rq_o;
   logic        mem_req_i;
   logic        mem_we_i;
   logic [1:0]  mem_size_i;
   logic [31:0] mem_addr_i;
   logic [31:0] mem_wdata_i;
   logic [31:0] mem_rdata_o;
   logic        mem_done_o;
   logic        mem_rq_o;
   logic [31:0] ram_a_o;
   logic [7:0]  ram_dout_i;
   logic [7:0]  ram_din_o;
   logic        ram_wr_o;

   logic [7:0]  ram     [0:4095];
   logic [7:0]  ref_mem [0:4095];
   logic        pre_fill;
   logic        pre_we;
   logic [11:0] pre_a;
   logic [7:0]  pre_d;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   mem_ctrl #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o),
      .if_done_o(if_done_o), .if_rq_o(if_rq_o),
      .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_size_i(mem_size_i),
      .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o),
      .mem_done_o(mem_done_o), .mem_rq_o(mem_rq_o),
      .ram_a_o(ram_a_o), .ram_dout_i(ram_dout_i), .ram_din_o(ram_din_o), .ram_wr_o(ram_wr_o)
   );

   function automatic logic [7:0] fill_pat(input int i);
      return 8'((i * 7 + 3) & 255);
   endfunction

   // external RAM: registered read, write strobe, plus a bench-side preload path
   always @(posedge clk) begin
      if (pre_fill) begin
         for (int i = 0; i < 4096; i++) ram[i] <= fill_pat(i);
      end else if (pre_we) begin
         ram[pre_a] <= pre_d;
      end else if (ram_wr_o) begin
         ram[ram_a_o[11:0]] <= ram_din_o;
      end
      ram_dout_i <= ram[ram_a_o[11:0]];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int nbytes(input bit is_if, input logic [1:0] sz);
      if (is_if) return 4;
      if (sz == 2'b10) return 2;
      if (sz == 2'b11) return 4;
      return 1;
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
      logic [31:0] v;
      logic [31:0] ai;
      v = 32'd0;
      for (int i = 0; i < n; i++) begin
         ai = a + 32'(i);
         v  = v | (32'(ref_mem[ai[11:0]]) << (8 * i));
      end
      return v;
   endfunction

   task automatic preload(input logic [11:0] a, input logic [7:0] d);
      pre_we = 1'b1;
      pre_a  = a;
      pre_d  = d;
      ref_mem[a] = d;
      tick();
      pre_we = 1'b0;
   endtask

   // one complete transfer starting in the current cycle (cycle 0)
   task automatic run_op(input bit is_if, input bit we, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input string tag, output logic [31:0] data);
      int          n;
      int          exp_lat;
      int          k;
      bit          done;
      bit          is_wr;
      logic [31:0] ak;
      logic [31:0] sh;
      logic [31:0] exp_data;
      is_wr    = we && !is_if;
      n        = nbytes(is_if, sz);
      exp_lat  = is_wr ? n : n + 1;
      exp_data = is_wr ? 32'd0 : ref_read(addr, n);
      if (is_if) begin
         if_req_i  = 1'b1;
         if_addr_i = addr;
      end else begin
         mem_req_i   = 1'b1;
         mem_we_i    = we;
         mem_size_i  = sz;
         mem_addr_i  = addr;
         mem_wdata_i = wd;
      end
      #1;
      done = 1'b0;
      data = 32'd0;
      for (k = 0; k <= 12; k++) begin
         if (k > 0) tick();
         done = is_if ? if_done_o : mem_done_o;
         if (done) break;
         chk({tag, "_rq_high"}, 32'(is_if ? if_rq_o : mem_rq_o), 32'd1);
         if (k < n) begin
            ak = addr + 32'(k);
            chk({tag, "_ram_a"}, ram_a_o, ak);
            chk({tag, "_ram_wr"}, 32'(ram_wr_o), 32'(is_wr));
            if (is_wr) begin
               sh = wd >> (8 * k);
               chk({tag, "_ram_din"}, 32'(ram_din_o), 32'(sh[7:0]));
            end
         end
      end
      chk({tag, "_latency"}, 32'(k), 32'(exp_lat));
      if (done) begin
         data = is_if ? if_data_o : mem_rdata_o;
         if (!is_wr) chk({tag, "_rdata"}, data, exp_data);
         chk({tag, "_rq_low_at_done"}, 32'(is_if ? if_rq_o : mem_rq_o), 32'd0);
      end
      tick();
      if_req_i  = 1'b0;
      mem_req_i = 1'b0;
      mem_we_i  = 1'b0;
      if (is_wr) begin
         for (int i = 0; i < n; i++) begin
            ak = addr + 32'(i);
            sh = wd >> (8 * i);
            ref_mem[ak[11:0]] = sh[7:0];
            chk({tag, "_ram_byte"}, 32'(ram[ak[11:0]]), 32'(sh[7:0]));
         end
         ak = addr + 32'(n);
         chk({tag, "_ram_neighbour"}, 32'(ram[ak[11:0]]), 32'(ref_mem[ak[11:0]]));
      end
   endtask

   initial begin
      logic [31:0] d;
      logic [31:0] a;
      logic [31:0] wd;
      logic [1:0]  sz;
      int          kind;
      int          md;
      int          fd;

      rst = 1'b1;
      if_req_i = 1'b0; if_addr_i = 32'd0;
      mem_req_i = 1'b0; mem_we_i = 1'b0; mem_size_i = 2'b00;
      mem_addr_i = 32'd0; mem_wdata_i = 32'd0;
      pre_fill = 1'b1; pre_we = 1'b0; pre_a = 12'd0; pre_d = 8'd0;
      for (int i = 0; i < 4096; i++) ref_mem[i] = fill_pat(i);
      tick();
      pre_fill = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;

      // reset state
      chk("rst_if_data", if_data_o, 32'd0);
      chk("rst_mem_rdata", mem_rdata_o, 32'd0);
      chk("rst_if_done", 32'(if_done_o), 32'd0);
      chk("rst_mem_done", 32'(mem_done_o), 32'd0);
      chk("rst_ram_a", ram_a_o, 32'd0);
      chk("rst_ram_din", 32'(ram_din_o), 32'd0);
      chk("rst_ram_wr", 32'(ram_wr_o), 32'd0);
      tick();

      preload(12'h100, 8'h13);
      preload(12'h101, 8'h05);
      preload(12'h102, 8'h00);
      preload(12'h103, 8'h00);
      preload(12'h040, 8'h34);
      preload(12'h041, 8'h12);

      // instruction fetch
      run_op(1'b1, 1'b0, 2'b00, 32'h100, 32'd0, "if_fetch", d);
      chk("if_fetch_word", d, 32'h0000_0513);

      // byte store
      run_op(1'b0, 1'b1, 2'b01, 32'h20, 32'hAABB_CCDD, "st_byte", d);

      // half load
      run_op(1'b0, 1'b0, 2'b10, 32'h40, 32'd0, "ld_half", d);
      chk("ld_half_value", d, 32'h0000_1234);

      // word store and size-00 store
      run_op(1'b0, 1'b1, 2'b11, 32'h60, 32'hDEAD_BEEF, "st_word", d);
      run_op(1'b0, 1'b1, 2'b00, 32'h70, 32'h1234_5678, "st_size0", d);

      // contention: MEM word load and IF fetch raised together
      if_req_i = 1'b1; if_addr_i = 32'h100;
      mem_req_i = 1'b1; mem_we_i = 1'b0; mem_size_i = 2'b11; mem_addr_i = 32'h40;
      #1;
      chk("cont_mem_first", ram_a_o, 32'h40);
      md = -1;
      fd = -1;
      for (int k = 0; k < 30 && fd < 0; k++) begin
         if (k > 0) begin
            tick();
            if (md >= 0) mem_req_i = 1'b0;
            #1;
         end
         if (md < 0) begin
            if (mem_done_o) begin
               md = k;
               chk("cont_mem_data", mem_rdata_o, ref_read(32'h40, 4));
            end else begin
               chk("cont_mem_rq", 32'(mem_rq_o), 32'd1);
            end
         end
         if (if_done_o) begin
            fd = k;
            chk("cont_if_data", if_data_o, 32'h0000_0513);
         end else begin
            chk("cont_if_rq", 32'(if_rq_o), 32'd1);
         end
      end
      chk("cont_mem_latency", 32'(md), 32'd5);
      chk("cont_if_after_mem", 32'(fd > md && md >= 0), 32'd1);
      tick();
      if_req_i = 1'b0;
      mem_req_i = 1'b0;

      // IF abort by address change in cycle 2
      if_req_i = 1'b1; if_addr_i = 32'h200;
      #1;
      chk("abort_c0_addr", ram_a_o, 32'h200);
      tick();
      chk("abort_c1_done", 32'(if_done_o), 32'd0);
      tick();
      if_addr_i = 32'h300;
      #1;
      chk("abort_c2_done", 32'(if_done_o), 32'd0);
      tick();
      run_op(1'b1, 1'b0, 2'b00, 32'h300, 32'd0, "abort_refetch", d);

      // reset in cycle 2 of a word store
      mem_req_i = 1'b1; mem_we_i = 1'b1; mem_size_i = 2'b11;
      mem_addr_i = 32'h80; mem_wdata_i = 32'h1122_3344;
      #1;
      tick();
      tick();
      rst = 1'b1;
      mem_req_i = 1'b0;
      mem_we_i = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      chk("rstw_ram_wr", 32'(ram_wr_o), 32'd0);
      chk("rstw_ram_a", ram_a_o, 32'd0);
      chk("rstw_ram_din", 32'(ram_din_o), 32'd0);
      chk("rstw_mem_done", 32'(mem_done_o), 32'd0);
      chk("rstw_if_data", if_data_o, 32'd0);
      chk("rstw_mem_rdata", mem_rdata_o, 32'd0);
      tick();
      chk("rstw_mem_done_next", 32'(mem_done_o), 32'd0);
      chk("rstw_byte0", 32'(ram[12'h080]), 32'h44);
      chk("rstw_byte1", 32'(ram[12'h081]), 32'h33);
      chk("rstw_byte3_kept", 32'(ram[12'h083]), 32'(ref_mem[12'h083]));
      ref_mem[12'h080] = 8'h44;
      ref_mem[12'h081] = 8'h33;
      run_op(1'b0, 1'b0, 2'b01, 32'h81, 32'd0, "rstw_after", d);
      chk("rstw_after_value", d, 32'h0000_0033);

      // address wrap at the top of the space
      run_op(1'b0, 1'b1, 2'b11, 32'hFFFF_FFFE, 32'hCAFE_F00D, "wrap_st", d);
      run_op(1'b0, 1'b0, 2'b11, 32'hFFFF_FFFE, 32'd0, "wrap_ld", d);
      chk("wrap_ld_value", d, 32'hCAFE_F00D);
      run_op(1'b1, 1'b0, 2'b00, 32'hFFFF_FFFF, 32'd0, "wrap_if", d);

      // randomized mix against the byte-array model
      for (int t = 0; t < 60; t++) begin
         kind = int'($urandom_range(0, 2));
         sz   = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
         else                           a = 32'h400 + 32'($urandom_range(0, 255));
         wd = $urandom;
         run_op(kind == 0, kind == 2, sz, a, wd, "rnd", d);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
